trace_retire_serializer: RTL and testbench
==========================================

Name: trace_retire_serializer

Overview:
- Consumer end of the retire trace interface: takes per-port retired-instruction records (pc, instruction, valid), one per retire port per cycle.
- Buffers them in program order in a FIFO and serialises each record as two 32-bit beats (pc, then instruction) on a valid/ready stream to a debug/trace sink.
- Sits beside the retire stage; never back-pressures the core. Overflow drops records and is reported through a sticky flag and a drop counter.

Parameters:
- RETIRE_PORTS, 2: number of retire ports sampled per cycle (1..4).
- DEPTH, 16: FIFO entries (power of two, >= 2*RETIRE_PORTS).
- DROP_CNT_W, 16: drop counter width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- retire_valid  in  RETIRE_PORTS  per-port record valid; port 0 is oldest
- retire_pc  in  32*RETIRE_PORTS  per-port pc; port i at bits [32i+31:32i]
- retire_instruction  in  32*RETIRE_PORTS  per-port instruction word, same packing
- m_valid  out  1  stream beat valid
- m_ready  in  1  sink accepts beat
- m_data  out  32  beat payload
- m_last  out  1  high on the instruction beat, the 2nd beat of each record
- overflow  out  1  sticky: at least one record dropped
- drop_count  out  DROP_CNT_W  records dropped, saturating
- clear_overflow  in  1  clears overflow and drop_count
- occupancy  out  $clog2(DEPTH)+1  FIFO entries currently held

Behaviour:
- Reset: rd/wr pointers = 0; count = 0; FSM = SEND_PC. Outputs: m_valid=0, m_data=0, m_last=0, overflow=0, drop_count=0, occupancy=0. Reset mid-record abandons the record. Reset overrides all other inputs in that cycle.
- Enqueue:
  - free = DEPTH - count, using the registered count at cycle start. A pop in the same cycle does not add space until the next cycle.
  - n = popcount(retire_valid).
  - Valid ports are compacted in ascending port index and written to wr_ptr, wr_ptr+1, ..., with pointer wrap modulo DEPTH.
  - If n > free: only the lowest-indexed `free` valid ports are written. The other n-free records are dropped.
  - Program order in the FIFO always matches port order.
- Drop accounting:
  - Any drop in a cycle sets overflow=1 and adds the dropped count to drop_count, saturating at 2^DROP_CNT_W-1.
  - clear_overflow without a drop: overflow=0, drop_count=0 next cycle.
  - clear_overflow with a drop in the same cycle: overflow=1, drop_count = that cycle's dropped count.
- Serializer FSM, 2 states:
  - SEND_PC: m_data = head.pc, m_last=0. On m_valid&&m_ready, go to SEND_INSTR.
  - SEND_INSTR: m_data = head.instruction, m_last=1. On m_valid&&m_ready, pop head (rd_ptr+1, count-1) and go to SEND_PC.
  - No transition without a handshake.
- Stream rules:
  - m_valid = (count != 0), combinational from registered count.
  - m_data and m_last are forced to 0 when m_valid=0.
  - Once m_valid=1, m_data and m_last stay stable until the handshake. The head is not overwritten while held: writes only target free slots.
- Latency: a record presented in cycle N gives m_valid=1 in cycle N+1 if the FIFO was empty. Minimum 2 cycles per record with m_ready held high.
- Simultaneous push and pop: count_next = count + written - popped.
- occupancy = count (registered).
- Full: count==DEPTH gives free=0, so every valid record that cycle is dropped.
- Empty: m_valid=0 and the FSM holds in SEND_PC.

Test Plan:
- Reset, then retire_valid=2'b01, pc=0x80000000, instr=0x00000013, m_ready=1.
  - m_valid rises next cycle.
  - Beats: 0x80000000 (last=0), then 0x00000013 (last=1).
  - occupancy returns to 0 after 2 handshakes.
- Same cycle: port0 pc=0x100/instr=0xA, port1 pc=0x104/instr=0xB; m_ready=1.
  - Beats in order: 0x100, 0xA, 0x104, 0xB.
  - m_last pattern: 0,1,0,1.
- Backpressure: hold m_ready=0 for 5 cycles mid-record (in SEND_INSTR).
  - m_data stays 0xA with m_last=1 throughout.
  - Record completes when m_ready rises.
- Overflow, DEPTH=16, m_ready=0:
  - Push 2 records/cycle for 8 cycles: occupancy=16.
  - 9th cycle, 2 valid: overflow=1, drop_count=2.
  - Next cycle, 1 valid: drop_count=3.
  - Drain: 16 records out in original order.
- Partial fit and clear:
  - occupancy=15, 2 valid: port0 stored, port1 dropped, drop_count +1.
  - clear_overflow alone: overflow=0, drop_count=0.
  - clear_overflow plus a 2-record drop in one cycle: overflow=1, drop_count=2.
- Wrap and reset:
  - Stream 40 records with random m_ready: data matches the scoreboard across pointer wrap.
  - Assert rst mid-record: all outputs 0 next cycle; the next record starts with its pc beat.

Source files
------------

// File: rtl/trace_retire_serializer.sv
//------------------------------------------------------------------------------
// Module   : trace_retire_serializer
// Purpose  : Buffers retired-instruction records in program order and emits
//            each as two 32-bit beats (pc, then instruction) on a stream.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trace_retire_serializer #(
    parameter int RETIRE_PORTS = 2,
    parameter int DEPTH        = 16,
    parameter int DROP_CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [RETIRE_PORTS-1:0]     retire_valid,
    input  logic [32*RETIRE_PORTS-1:0]  retire_pc,
    input  logic [32*RETIRE_PORTS-1:0]  retire_instruction,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [31:0]                 m_data,
    output logic                        m_last,
    output logic                        overflow,
    output logic [DROP_CNT_W-1:0]       drop_count,
    input  logic                        clear_overflow,
    output logic [$clog2(DEPTH):0]      occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [DROP_CNT_W:0] DROP_MAX = {1'b0, {DROP_CNT_W{1'b1}}};

    typedef enum logic [0:0] {
        SEND_PC    = 1'b0,
        SEND_INSTR = 1'b1
    } state_t;

    state_t                 state_q;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0]  drop_count_q, drop_count_d;

    logic [31:0]            pc_mem    [DEPTH];
    logic [31:0]            instr_mem [DEPTH];

    logic [CW-1:0]          free_slots;
    logic [CW-1:0]          n_valid;
    logic [CW-1:0]          n_write;
    logic [CW-1:0]          n_drop;
    logic [RETIRE_PORTS-1:0] wr_en;
    logic [AW-1:0]          wr_addr [RETIRE_PORTS];
    logic [DROP_CNT_W:0]    drop_sum;
    logic                   hs;
    logic                   pop;

    assign free_slots = CW'(DEPTH) - count_q;
    assign m_valid    = (count_q != '0);
    assign hs         = m_valid && m_ready;
    assign pop        = hs && (state_q == SEND_INSTR);

    // Compact valid ports in ascending order; only the first free_slots are stored.
    always_comb begin
        n_valid = '0;
        n_write = '0;
        wr_en   = '0;
        for (int i = 0; i < RETIRE_PORTS; i++) begin
            wr_addr[i] = wr_ptr_q + AW'(n_valid);
            if (retire_valid[i]) begin
                if (n_valid < free_slots) begin
                    wr_en[i] = 1'b1;
                    n_write  = n_write + CW'(1);
                end
                n_valid = n_valid + CW'(1);
            end
        end
        n_drop = n_valid - n_write;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(n_write);
        count_d  = count_q + n_write - CW'(pop);
        drop_sum = {1'b0, drop_count_q} + (DROP_CNT_W+1)'(n_drop);
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (n_drop != '0) begin
            overflow_d   = 1'b1;
            if (clear_overflow) begin
                drop_count_d = DROP_CNT_W'(n_drop);
            end else if (drop_sum > DROP_MAX) begin
                drop_count_d = {DROP_CNT_W{1'b1}};
            end else begin
                drop_count_d = drop_sum[DROP_CNT_W-1:0];
            end
        end else if (clear_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    // Storage has no reset; only slots counted by count_q are ever read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RETIRE_PORTS; i++) begin
            if (!rst && wr_en[i]) begin
                pc_mem[wr_addr[i]]    <= retire_pc[32*i +: 32];
                instr_mem[wr_addr[i]] <= retire_instruction[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SEND_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            if (hs) begin
                state_q <= (state_q == SEND_PC) ? SEND_INSTR : SEND_PC;
            end
        end
    end

    always_comb begin
        m_data = '0;
        m_last = 1'b0;
        if (m_valid) begin
            m_last = (state_q == SEND_INSTR);
            m_data = m_last ? instr_mem[rd_ptr_q] : pc_mem[rd_ptr_q];
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
    assign occupancy  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_retire_serializer.sv
// Bench for trace_retire_serializer: directed steps and random traffic checked
// against a queue-of-records reference model.
`default_nettype none

module tb_trace_retire_serializer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rv;
    logic [63:0] rpc, rin;
    logic        m_valid, m_ready, m_last, overflow, clr;
    logic [31:0] m_data;
    logic [15:0] drop_count;
    logic [4:0]  occupancy;

    trace_retire_serializer #(.RETIRE_PORTS(2), .DEPTH(DEPTH), .DROP_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .retire_valid(rv), .retire_pc(rpc),
        .retire_instruction(rin), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .overflow(overflow),
        .drop_count(drop_count), .clear_overflow(clr), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: records in order, plus which beat of the head is next.
    logic [63:0] q[$];
    bit          beat_instr = 0;
    bit          m_ovf = 0;
    int          m_dc = 0;
    bit          do_check = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_data;
        exp_data = 32'h0;
        if (q.size() != 0) exp_data = beat_instr ? q[0][31:0] : q[0][63:32];
        chk("m_valid", m_valid, q.size() != 0);
        chk("m_data", m_data, exp_data);
        chk("m_last", m_last, (q.size() != 0) && beat_instr);
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, m_dc);
        chk("occupancy", occupancy, q.size());
    endtask

    task automatic model_step();
        int fr, nd;
        if (rst) begin
            q.delete();
            beat_instr = 0;
            m_ovf = 0;
            m_dc  = 0;
            return;
        end
        fr = DEPTH - q.size();
        nd = 0;
        if (q.size() != 0 && m_ready) begin
            if (beat_instr) void'(q.pop_front());
            beat_instr = !beat_instr;
        end
        for (int p = 0; p < 2; p++) begin
            if (rv[p]) begin
                if (fr > 0) begin
                    q.push_back({rpc[32*p +: 32], rin[32*p +: 32]});
                    fr--;
                end else begin
                    nd++;
                end
            end
        end
        if (nd != 0) begin
            m_ovf = 1;
            m_dc  = clr ? nd : ((m_dc + nd > 65535) ? 65535 : m_dc + nd);
        end else if (clr) begin
            m_ovf = 0;
            m_dc  = 0;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (do_check) check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] in0,
                         input logic [31:0] pc1, input logic [31:0] in1,
                         input logic rdy, input logic c);
        rv = v;
        rpc = {pc1, pc0};
        rin = {in1, in0};
        m_ready = rdy;
        clr = c;
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
        cyc();
        do_check = 1;
        cyc();
        rst = 1'b0;

        // Single record through the stream
        drive(2'b01, 32'h8000_0000, 32'h0000_0013, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc();
        chk("first_valid", m_valid, 1'b1);
        chk("first_pc", m_data, 32'h8000_0000);
        drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
        repeat (3) cyc();
        chk("first_occ0", occupancy, 5'd0);

        // Two records in one cycle, backpressure mid-record
        drive(2'b11, 32'h100, 32'hA, 32'h104, 32'hB, 1'b1, 1'b0);
        cyc();
        drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
        cyc();
        m_ready = 1'b0;
        repeat (5) cyc();
        chk("bp_data", m_data, 32'hA);
        chk("bp_last", m_last, 1'b1);
        m_ready = 1'b1;
        repeat (4) cyc();

        // Fill to full, then overflow
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 32'h1000 + 16*i, 32'h2000 + i, 32'h1008 + 16*i, 32'h3000 + i, 1'b0, 1'b0);
            cyc();
        end
        chk("full_occ", occupancy, 5'd16);
        drive(2'b11, 32'hDEAD, 32'hDEAD, 32'hBEEF, 32'hBEEF, 1'b0, 1'b0);
        cyc();
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_drop2", drop_count, 16'd2);
        drive(2'b01, 32'hDEAD, 32'hDEAD, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        chk("ovf_drop3", drop_count, 16'd3);
        drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
        repeat (34) cyc();

        // Partial fit, clear alone, clear with drop
        for (int i = 0; i < 8; i++) begin
            drive((i == 7) ? 2'b01 : 2'b11, 32'h5000 + i, 32'h6000 + i, 32'h5100 + i, 32'h6100 + i, 1'b0, 1'b0);
            cyc();
        end
        chk("part_occ15", occupancy, 5'd15);
        drive(2'b11, 32'h7000, 32'h7001, 32'h7002, 32'h7003, 1'b0, 1'b0);
        cyc();
        chk("part_occ16", occupancy, 5'd16);
        chk("part_drop", drop_count, 16'd4);
        drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b1);
        cyc();
        chk("clr_ovf", overflow, 1'b0);
        chk("clr_drop", drop_count, 16'd0);
        drive(2'b11, 32'h7100, 32'h7101, 32'h7102, 32'h7103, 1'b0, 1'b1);
        cyc();
        chk("clrdrop_ovf", overflow, 1'b1);
        chk("clrdrop_cnt", drop_count, 16'd2);
        drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
        repeat (34) cyc();

        // Random traffic across pointer wrap
        for (int i = 0; i < 80; i++) begin
            drive(2'($urandom_range(0, 3)) & {1'b1, ($urandom_range(0, 1) == 1)},
                  $urandom, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
            cyc();
        end
        drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 100 && q.size() != 0; i++) cyc();
        chk("rand_drained", occupancy, 5'd0);

        // Reset mid-record
        drive(2'b01, 32'hCAFE_0000, 32'hCAFE_0001, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc();
        drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
        cyc();
        chk("pre_rst_last", m_last, 1'b1);
        rst = 1'b1;
        drive(2'b11, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1, 1'b1);
        cyc();
        rst = 1'b0;
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_data", m_data, 32'h0);
        chk("rst_occ", occupancy, 5'd0);
        drive(2'b01, 32'hF00D_0000, 32'hF00D_0001, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        chk("post_rst_pc", m_data, 32'hF00D_0000);
        chk("post_rst_last", m_last, 1'b0);
        drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
